// File: rtl/iob_cache_front_end_pipe_if.sv
// IOb front-end bus: request/accept handshake plus in-order read return.
interface iob_cache_front_end_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output avalid, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  avalid, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/iob_cache_front_end_pipe.sv
// Pipelined IOb front-end: in-order request queue steering to data or control back-end.
// Optional statistics counters are built when IOB_CACHE_FE_STATS_EN is defined.
module iob_cache_front_end_pipe #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2,
  parameter int USE_CTRL    = 0,
  parameter int CTRL_ADDR_W = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cke_i,
  iob_cache_front_end_pipe_if.slave     iob,
  output logic                          data_req_o,
  output logic [ADDR_W-USE_CTRL-1:0]    data_addr_o,
  output logic [DATA_W-1:0]             data_wdata_o,
  output logic [DATA_W/8-1:0]           data_wstrb_o,
  input  logic [DATA_W-1:0]             data_rdata_i,
  input  logic                          data_ack_i,
  output logic                          ctrl_req_o,
  output logic [CTRL_ADDR_W-1:0]        ctrl_addr_o,
  input  logic [DATA_W-1:0]             ctrl_rdata_i,
  input  logic                          ctrl_ack_i,
  output logic [$clog2(DEPTH):0]        occupancy_o
`ifdef IOB_CACHE_FE_STATS_EN
  ,
  output logic [31:0]                   stat_rd_o,
  output logic [31:0]                   stat_wr_o,
  output logic [31:0]                   stat_stall_o
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DA_W   = ADDR_W - USE_CTRL;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic              q_ctrl_p0  [DEPTH];
  logic [DA_W-1:0]   q_addr_p0  [DEPTH];
  logic [DATA_W-1:0] q_wdata_p0 [DEPTH];
  logic [STRB_W-1:0] q_wstrb_p0 [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  logic              in_ctrl, push, pop;
  logic              head_valid, head_ctrl, head_rd, head_ack;
  logic [DA_W-1:0]   head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [STRB_W-1:0] head_wstrb;

  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  assign iob.ready  = (count < FULL_CNT);
  assign in_ctrl    = (USE_CTRL != 0) && iob.addr[ADDR_W-1];
  assign push       = cke_i & iob.avalid & iob.ready;

  assign head_valid = (count != '0);
  assign head_ctrl  = q_ctrl_p0[rd_ptr];
  assign head_addr  = q_addr_p0[rd_ptr];
  assign head_wdata = q_wdata_p0[rd_ptr];
  assign head_wstrb = q_wstrb_p0[rd_ptr];
  assign head_rd    = ~(|head_wstrb);
  // Only an ack on the head entry's own channel completes it
  assign head_ack   = head_ctrl ? ctrl_ack_i : data_ack_i;
  assign pop        = cke_i & head_valid & head_ack;

  // p0: queue control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cke_i) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_ctrl_p0[wr_ptr]  <= in_ctrl;
      q_addr_p0[wr_ptr]  <= iob.addr[DA_W-1:0];
      q_wdata_p0[wr_ptr] <= iob.wdata;
      q_wstrb_p0[wr_ptr] <= iob.wstrb;
    end
  end

  // p1: read return
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else if (cke_i) begin
      vld_p1 <= pop & head_rd;
      if (pop & head_rd) rdata_p1 <= head_ctrl ? ctrl_rdata_i : data_rdata_i;
    end
  end

  assign iob.rvalid  = vld_p1;
  assign iob.rdata   = rdata_p1;
  assign occupancy_o = count;

  // Back-end fields are zeroed while no request is pending on that channel
  assign data_req_o   = head_valid & ~head_ctrl;
  assign data_addr_o  = data_req_o ? head_addr  : '0;
  assign data_wdata_o = data_req_o ? head_wdata : '0;
  assign data_wstrb_o = data_req_o ? head_wstrb : '0;

  generate
    if (USE_CTRL != 0) begin : g_ctrl
      assign ctrl_req_o  = head_valid & head_ctrl;
      assign ctrl_addr_o = ctrl_req_o ? head_addr[CTRL_ADDR_W-1:0] : '0;
    end else begin : g_no_ctrl
      assign ctrl_req_o  = 1'b0;
      assign ctrl_addr_o = '0;
    end
  endgenerate

`ifdef IOB_CACHE_FE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_rd_o    <= '0;
      stat_wr_o    <= '0;
      stat_stall_o <= '0;
    end else if (cke_i) begin
      if (push & ~(|iob.wstrb)) stat_rd_o <= stat_rd_o + 32'd1;
      if (push &  (|iob.wstrb)) stat_wr_o <= stat_wr_o + 32'd1;
      if (iob.avalid & ~iob.ready) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_cache_front_end_pipe.sv
// Bench for iob_cache_front_end_pipe (DEPTH=2, USE_CTRL=1): directed scenarios then random
// traffic, every cycle compared against a queue-based reference model.
module tb_iob_cache_front_end_pipe;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  typedef struct {
    logic        ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, cke;
  logic        data_req, data_ack, ctrl_req, ctrl_ack;
  logic [30:0] data_addr;
  logic [31:0] data_wdata, data_rdata, ctrl_rdata;
  logic [3:0]  data_wstrb;
  logic [4:0]  ctrl_addr;
  logic [1:0]  occupancy;
`ifdef IOB_CACHE_FE_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_stall;
  int          m_rd, m_wr, m_stall;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  ent_t        mq[$];
  logic        m_rvalid;
  logic [31:0] m_rdata;

  iob_cache_front_end_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) iob_bus ();

  iob_cache_front_end_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .USE_CTRL(1), .CTRL_ADDR_W(5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .iob(iob_bus),
    .data_req_o(data_req), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_wstrb_o(data_wstrb), .data_rdata_i(data_rdata), .data_ack_i(data_ack),
    .ctrl_req_o(ctrl_req), .ctrl_addr_o(ctrl_addr), .ctrl_rdata_i(ctrl_rdata),
    .ctrl_ack_i(ctrl_ack), .occupancy_o(occupancy)
`ifdef IOB_CACHE_FE_STATS_EN
    , .stat_rd_o(stat_rd), .stat_wr_o(stat_wr), .stat_stall_o(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: one clock edge applied to the queue with the inputs currently driven
  task automatic model_update();
    bit   pop_e, push_e;
    ent_t n;
    if (rst) begin
      mq.delete();
      m_rvalid = 1'b0;
      m_rdata  = '0;
`ifdef IOB_CACHE_FE_STATS_EN
      m_rd = 0; m_wr = 0; m_stall = 0;
`endif
    end else if (cke) begin
      pop_e  = (mq.size() > 0) && (mq[0].ctrl ? ctrl_ack : data_ack);
      push_e = iob_bus.avalid && (mq.size() < DEPTH);
      m_rvalid = pop_e && (mq[0].wstrb == 4'h0);
      if (m_rvalid) m_rdata = mq[0].ctrl ? ctrl_rdata : data_rdata;
`ifdef IOB_CACHE_FE_STATS_EN
      if (iob_bus.avalid && !push_e) m_stall++;
      if (push_e && iob_bus.wstrb == 4'h0) m_rd++;
      if (push_e && iob_bus.wstrb != 4'h0) m_wr++;
`endif
      if (pop_e) void'(mq.pop_front());
      if (push_e) begin
        n.ctrl  = iob_bus.addr[31];
        n.addr  = iob_bus.addr;
        n.wdata = iob_bus.wdata;
        n.wstrb = iob_bus.wstrb;
        mq.push_back(n);
      end
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("ready",     iob_bus.ready, 64'(sz < DEPTH));
    chk("occupancy", occupancy, 64'(sz));
    chk("data_req",  data_req, 64'((sz > 0) && !mq[0].ctrl));
    chk("ctrl_req",  ctrl_req, 64'((sz > 0) && mq[0].ctrl));
    if (sz > 0 && !mq[0].ctrl) begin
      chk("data_addr",  data_addr,  64'(mq[0].addr[30:0]));
      chk("data_wdata", data_wdata, 64'(mq[0].wdata));
      chk("data_wstrb", data_wstrb, 64'(mq[0].wstrb));
    end
    if (sz > 0 && mq[0].ctrl) chk("ctrl_addr", ctrl_addr, 64'(mq[0].addr[4:0]));
    chk("rvalid", iob_bus.rvalid, 64'(m_rvalid));
    chk("rdata",  iob_bus.rdata,  64'(m_rdata));
`ifdef IOB_CACHE_FE_STATS_EN
    chk("stat_rd",    stat_rd,    64'(m_rd));
    chk("stat_wr",    stat_wr,    64'(m_wr));
    chk("stat_stall", stat_stall, 64'(m_stall));
`endif
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    rst = 1'b0; cke = 1'b1;
    iob_bus.avalid = 1'b0; iob_bus.addr = '0; iob_bus.wdata = '0; iob_bus.wstrb = '0;
    data_ack = 1'b0; ctrl_ack = 1'b0; data_rdata = '0; ctrl_rdata = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    iob_bus.avalid = 1'b1; iob_bus.addr = a; iob_bus.wdata = wd; iob_bus.wstrb = ws;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_ready", iob_bus.ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_ctrl_req", ctrl_req, 0);
    chk("rst_rvalid", iob_bus.rvalid, 0);
    chk("rst_rdata", iob_bus.rdata, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_ctrl_addr", ctrl_addr, 0);

    // Read with ack one cycle after the request appears
    req(32'h10, 32'h0, 4'h0); step();
    chk("t1_req", data_req, 1);
    chk("t1_addr", data_addr, 31'h10);
    idle(); step();
    chk("t1_norv", iob_bus.rvalid, 0);
    data_ack = 1'b1; data_rdata = 32'hCAFEF00D; step();
    idle();
    chk("t1_rvalid", iob_bus.rvalid, 1);
    chk("t1_rdata", iob_bus.rdata, 32'hCAFEF00D);
    step();
    chk("t1_pulse", iob_bus.rvalid, 0);
    chk("t1_hold", iob_bus.rdata, 32'hCAFEF00D);

    // Write with immediate ack
    req(32'h20, 32'h11223344, 4'hF); step();
    idle();
    chk("t2_wstrb", data_wstrb, 4'hF);
    chk("t2_wdata", data_wdata, 32'h11223344);
    data_ack = 1'b1; step();
    idle();
    chk("t2_norv", iob_bus.rvalid, 0);
    chk("t2_occ", occupancy, 0);

    // Three back-to-back reads, acks withheld
    req(32'h100, 0, 0); step();
    req(32'h104, 0, 0); step();
    req(32'h108, 0, 0);
    chk("t3_full", iob_bus.ready, 0);
    chk("t3_occ", occupancy, 2);
    step();
    chk("t3_stall", occupancy, 2);
    data_ack = 1'b1; data_rdata = 32'hA1; step();
    chk("t3_ready", iob_bus.ready, 1);
    chk("t3_rd1", iob_bus.rdata, 32'hA1);
    data_rdata = 32'hA2; step();
    iob_bus.avalid = 1'b0; data_rdata = 32'hA3;
    chk("t3_rd2", iob_bus.rdata, 32'hA2);
    step();
    chk("t3_rd3", iob_bus.rdata, 32'hA3);
    idle(); step();

    // Control channel read
    req(32'h8000_0004, 0, 0); step();
    idle();
    chk("t4_ctrl_req", ctrl_req, 1);
    chk("t4_ctrl_addr", ctrl_addr, 5'h04);
    chk("t4_data_req", data_req, 0);
    data_ack = 1'b1; step();
    chk("t4_wrong_ch", occupancy, 1);
    idle(); ctrl_ack = 1'b1; ctrl_rdata = 32'h5; step();
    idle();
    chk("t4_rvalid", iob_bus.rvalid, 1);
    chk("t4_rdata", iob_bus.rdata, 32'h5);

    // Clock enable low freezes everything, including a pending ack
    req(32'h40, 0, 0); step();
    idle(); cke = 1'b0; data_ack = 1'b1; data_rdata = 32'h77; step();
    chk("cke_occ", occupancy, 1);
    chk("cke_rv", iob_bus.rvalid, 0);
    idle(); step();

    // Reset with two entries queued
    req(32'h200, 0, 0); step();
    req(32'h204, 0, 0); step();
    idle(); rst = 1'b1; step();
    rst = 1'b0;
    chk("t5_occ", occupancy, 0);
    chk("t5_req", data_req, 0);
    chk("t5_rv", iob_bus.rvalid, 0);
    chk("t5_ready", iob_bus.ready, 1);

`ifdef IOB_CACHE_FE_STATS_EN
    do_reset();
    req(32'h300, 0, 0); step();
    req(32'h304, 32'h1, 4'h3); step();
    for (int i = 0; i < 4; i++) step();
    idle(); data_ack = 1'b1; step(); step();
    req(32'h308, 0, 0); step(); step();
    idle(); step(); step();
    chk("t6_rd", stat_rd, 3);
    chk("t6_wr", stat_wr, 1);
    chk("t6_stall", stat_stall, 4);
`endif

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      cke = rst || ($urandom_range(0, 7) != 0);
      iob_bus.avalid = $urandom_range(0, 1);
      iob_bus.addr   = $urandom;
      iob_bus.wdata  = $urandom;
      iob_bus.wstrb  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      data_ack       = $urandom_range(0, 1);
      ctrl_ack       = $urandom_range(0, 1);
      data_rdata     = $urandom;
      ctrl_rdata     = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
